// File: rtl/dmux4way16_router.sv
// dmux4way16_router: clocked 1-to-4 word demultiplexer.
// One producer stream is steered by sel into one of four small per-channel FIFOs,
// each drained by its own valid/ready consumer. Heads are presented from storage
// and forced to zero while a channel is empty.
// Optional build macro: DMUX4_STATS_EN adds per-channel accepted-word counters
// cnt1..cnt4 (16 bit, wrapping). Without it the counter ports and logic are absent.
module dmux4way16_router #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
`ifdef DMUX4_STATS_EN
  ,
  output logic [15:0]      cnt1,
  output logic [15:0]      cnt2,
  output logic [15:0]      cnt3,
  output logic [15:0]      cnt4
`endif
);

  // Pointer width wraps naturally because DEPTH is a power of two.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Occupancy needs one extra bit so that "DEPTH words" is representable.
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [3:0]       full_w;
  logic [3:0]       push_w;
  logic [3:0]       pop_w;
  logic [WIDTH-1:0] head_w [4];
  logic             accept_w;

  // Readiness only reflects the channel currently addressed; a full channel
  // refuses even if it is being popped this cycle (no pass-through).
  assign in_ready = !full_w[sel];
  assign accept_w = in_valid && in_ready;

  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign push_w[gi]    = accept_w && (sel == 2'(gi));
    // A pop request on an empty channel is simply ignored.
    assign pop_w[gi]     = out_valid[gi] && out_ready[gi];
    assign full_w[gi]    = (occ_q == OCC_FULL);
    assign out_valid[gi] = (occ_q != '0);
    assign head_w[gi]    = out_valid[gi] ? mem_q[rd_ptr_q] : '0;

    // Next-state pointers and occupancy from this cycle's push/pop pair.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push_w[gi]) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_w[gi]) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push_w[gi], pop_w[gi]})
        2'b10:   occ_d = occ_q + OCC_ONE;
        2'b01:   occ_d = occ_q - OCC_ONE;
        default: occ_d = occ_q;
      endcase
    end

    // Channel control state; reset discards everything queued.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        occ_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        occ_q    <= occ_d;
      end
    end

    // Word storage needs no reset: heads are gated to zero while empty.
    always_ff @(posedge clk) begin
      if (push_w[gi]) begin
        mem_q[wr_ptr_q] <= in;
      end
    end

`ifdef DMUX4_STATS_EN
    logic [15:0] stat_q;

    // Accepted-word counter, wraps at 16 bits; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stat_q <= '0;
      end else if (push_w[gi]) begin
        stat_q <= stat_q + 16'd1;
      end
    end
`endif
  end

  assign out1 = head_w[0];
  assign out2 = head_w[1];
  assign out3 = head_w[2];
  assign out4 = head_w[3];

`ifdef DMUX4_STATS_EN
  assign cnt1 = g_ch[0].stat_q;
  assign cnt2 = g_ch[1].stat_q;
  assign cnt3 = g_ch[2].stat_q;
  assign cnt4 = g_ch[3].stat_q;
`endif

endmodule

// File: tb/tb_dmux4way16_router.sv
// Testbench for dmux4way16_router: per-channel queues model the expected
// contents; each scenario task drives cycles and compares outputs inline.
module tb_dmux4way16_router;
  localparam int WIDTH = 16;
  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [WIDTH-1:0]  in;
  logic [1:0]        sel;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  out1, out2, out3, out4;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
`ifdef DMUX4_STATS_EN
  logic [15:0]       cnt1, cnt2, cnt3, cnt4;
`endif

  int tests  = 0;
  int errors = 0;

  // Reference model: one queue of words per channel.
  logic [WIDTH-1:0] mq [4][$];

  always #5 clk = ~clk;

  dmux4way16_router #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .sel      (sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .out4     (out4),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef DMUX4_STATS_EN
    ,
    .cnt1     (cnt1),
    .cnt2     (cnt2),
    .cnt3     (cnt3),
    .cnt4     (cnt4)
`endif
  );

  function automatic logic [WIDTH-1:0] exp_out(int k);
    return (mq[k].size() > 0) ? mq[k][0] : '0;
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = (mq[k].size() > 0);
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] act_out(int k);
    case (k)
      0:       return out1;
      1:       return out2;
      2:       return out3;
      default: return out4;
    endcase
  endfunction

  // Drive one cycle from a negedge, update the model at the posedge,
  // then return to the next negedge with inputs idle.
  task automatic drive_cycle(input logic [WIDTH-1:0] d, input logic [1:0] s,
                             input logic v, input logic [3:0] r);
    bit do_push;
    in = d; sel = s; in_valid = v; out_ready = r;
    @(posedge clk);
    do_push = v && (mq[s].size() < DEPTH);
    for (int k = 0; k < 4; k++)
      if (r[k] && mq[k].size() > 0) void'(mq[k].pop_front());
    if (do_push) mq[s].push_back(d);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 4'b0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) mq[k].delete();
    in_valid = 1'b0; out_ready = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in = '0; sel = 2'b00; in_valid = 1'b0; out_ready = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(16'h1111, 2'b00, 1'b1, 4'b0000);
    drive_cycle(16'h2222, 2'b11, 1'b1, 4'b0000);
    tests++;
    if (out_valid !== 4'b1001) begin
      errors++; $display("FAIL reset_pre_valid: got %b expected 1001", out_valid);
    end
    // Assert reset mid-cycle; outputs must clear without a clock edge.
    #2 rst_n = 1'b0;
    for (int k = 0; k < 4; k++) mq[k].delete();
    #1;
    tests++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL reset_valid: got %b expected 0000", out_valid);
    end
    tests++;
    if ({out1, out2, out3, out4} !== 64'h0) begin
      errors++; $display("FAIL reset_outs: got %h expected 0", {out1, out2, out3, out4});
    end
    tests++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: got valid=%b rdy=%b expected 0000/1", out_valid, in_ready);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_routing();
    drive_cycle(16'hdadf, 2'b00, 1'b1, 4'b0000);
    tests++;
    if (out_valid !== 4'b0001 || out1 !== 16'hdadf) begin
      errors++; $display("FAIL route_latency: got valid=%b out1=%h expected 0001/dadf", out_valid, out1);
    end
    drive_cycle(16'haaaf, 2'b01, 1'b1, 4'b0000);
    drive_cycle(16'hbdef, 2'b10, 1'b1, 4'b0000);
    drive_cycle(16'h1245, 2'b11, 1'b1, 4'b0000);
    tests++;
    if (out_valid !== 4'b1111) begin
      errors++; $display("FAIL route_valid: got %b expected 1111", out_valid);
    end
    tests++;
    if ({out1, out2, out3, out4} !== {16'hdadf, 16'haaaf, 16'hbdef, 16'h1245}) begin
      errors++; $display("FAIL route_data: got %h %h %h %h expected dadf aaaf bdef 1245", out1, out2, out3, out4);
    end
    $display("[TB] test_routing done");
  endtask

  task automatic test_full();
    do_reset();
    drive_cycle(16'h0001, 2'b10, 1'b1, 4'b0000);
    drive_cycle(16'h0002, 2'b10, 1'b1, 4'b0000);
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready);
    end
    sel = 2'b00; #1;
    tests++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL full_other_ready: got %b expected 1", in_ready);
    end
    tests++;
    if (out3 !== 16'h0001) begin
      errors++; $display("FAIL full_head0: got %h expected 0001", out3);
    end
    drive_cycle(16'h0000, 2'b00, 1'b0, 4'b0100);
    tests++;
    if (out3 !== 16'h0002) begin
      errors++; $display("FAIL full_head1: got %h expected 0002", out3);
    end
    drive_cycle(16'h0000, 2'b00, 1'b0, 4'b0100);
    tests++;
    if (out_valid[2] !== 1'b0 || out3 !== 16'h0) begin
      errors++; $display("FAIL full_drained: got v=%b out3=%h expected 0/0000", out_valid[2], out3);
    end
    // Push into a full channel while it is popped: the push must be refused.
    drive_cycle(16'h0005, 2'b10, 1'b1, 4'b0000);
    drive_cycle(16'h0006, 2'b10, 1'b1, 4'b0000);
    drive_cycle(16'h0007, 2'b10, 1'b1, 4'b0100);
    tests++;
    if (out_valid[2] !== 1'b1 || out3 !== 16'h0006) begin
      errors++; $display("FAIL full_no_passthru: got v=%b out3=%h expected 1/0006", out_valid[2], out3);
    end
    drive_cycle(16'h0000, 2'b10, 1'b0, 4'b0100);
    tests++;
    if (out_valid[2] !== 1'b0) begin
      errors++; $display("FAIL full_dropped: got v=%b expected 0", out_valid[2]);
    end
    $display("[TB] test_full done");
  endtask

  task automatic test_concurrent();
    do_reset();
    drive_cycle(16'h3a3a, 2'b01, 1'b1, 4'b0000);
    drive_cycle(16'h4b4b, 2'b01, 1'b1, 4'b0010);
    tests++;
    if (out_valid[1] !== 1'b1 || out2 !== 16'h4b4b) begin
      errors++; $display("FAIL conc_pushpop: got v=%b out2=%h expected 1/4b4b", out_valid[1], out2);
    end
    drive_cycle(16'h0000, 2'b01, 1'b0, 4'b0010);
    tests++;
    if (out_valid[1] !== 1'b0) begin
      errors++; $display("FAIL conc_one_word: got v=%b expected 0", out_valid[1]);
    end
    drive_cycle(16'h5c5c, 2'b10, 1'b1, 4'b0100);
    tests++;
    if (out_valid[2] !== 1'b1 || out3 !== 16'h5c5c) begin
      errors++; $display("FAIL conc_empty: got v=%b out3=%h expected 1/5c5c", out_valid[2], out3);
    end
    drive_cycle(16'h0000, 2'b10, 1'b0, 4'b0100);
    tests++;
    if (out_valid[2] !== 1'b0) begin
      errors++; $display("FAIL conc_empty_count: got v=%b expected 0", out_valid[2]);
    end
    $display("[TB] test_concurrent done");
  endtask

  task automatic test_random();
    logic [3:0] ev;
    logic       er;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive_cycle(WIDTH'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0),
                  4'($urandom));
      ev = exp_valid();
      er = (mq[sel].size() < DEPTH);
      #1;
      tests++;
      if (out_valid !== ev) begin
        errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", n, out_valid, ev);
      end
      tests++;
      if (in_ready !== er) begin
        errors++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", n, in_ready, er);
      end
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (act_out(k) !== exp_out(k)) begin
          errors++; $display("FAIL rand_out%0d[%0d]: got %h expected %h", k + 1, n, act_out(k), exp_out(k));
        end
      end
    end
    $display("[TB] test_random done");
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int k = 0; k < 8; k++)
      drive_cycle(WIDTH'($urandom), 2'(k % 4), 1'b1, 4'b0000);
    tests++;
    if (out_valid !== 4'b1111 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_filled: got v=%b rdy=%b expected 1111/0", out_valid, in_ready);
    end
    #2 rst_n = 1'b0;
    for (int k = 0; k < 4; k++) mq[k].delete();
    #1;
    tests++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_cleared: got v=%b rdy=%b expected 0000/1", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(16'hbeef, 2'b11, 1'b1, 4'b0000);
    tests++;
    if (out_valid !== 4'b1000 || out4 !== 16'hbeef) begin
      errors++; $display("FAIL mid_first_push: got v=%b out4=%h expected 1000/beef", out_valid, out4);
    end
    $display("[TB] test_reset_midstream done");
  endtask

`ifdef DMUX4_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int n = 0; n < 65537; n++)
      drive_cycle(WIDTH'($urandom), 2'b01, 1'b1, 4'b0010);
    tests++;
    if (cnt2 !== 16'h0001) begin
      errors++; $display("FAIL stats_cnt2: got %h expected 0001", cnt2);
    end
    tests++;
    if ({cnt1, cnt3, cnt4} !== 48'h0) begin
      errors++; $display("FAIL stats_others: got %h %h %h expected 0 0 0", cnt1, cnt3, cnt4);
    end
    $display("[TB] test_stats done");
  endtask
`endif

  initial begin
    test_reset();
    test_routing();
    test_full();
    test_concurrent();
    test_random();
    test_reset_midstream();
`ifdef DMUX4_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  // Safety bound so the run always ends on its own.
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
